// File: rtl/pdw_tx_arbiter_pkg.sv
// rtl/pdw_tx_arbiter_pkg.sv - shared types and sizing for the PDW transmit arbiter
// Holds the FSM state encoding, the snapshot width derivation and a counter
// width helper used by the arbiter and its sub-module.
package pdw_tx_arbiter_pkg;

  // Snapshot layout: NUM_TAPS samples of SAMPLE_WIDTH bits plus an absolute timestamp.
  localparam int SAMPLE_WIDTH   = 16;
  localparam int NUM_TAPS       = 10;
  localparam int ABS_TIME_WIDTH = 32;
  localparam int SS_BUFF_SZ_DEF = SAMPLE_WIDTH * NUM_TAPS + ABS_TIME_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DONE   = 2'd2,
    ST_GAP    = 2'd3
  } pdw_state_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pdw_tx_arbiter_rr_arbiter.sv
// rtl/pdw_tx_arbiter_rr_arbiter.sv - combinational round-robin winner pick
// Ports:
//   eligible_i  in   NUM_CH  channels competing this cycle
//   ptr_i       in   CH_W    highest-priority channel index
//   winner_o    out  CH_W    first eligible index at or after ptr_i, wrapping
//   valid_o     out  1       at least one channel eligible
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         eligible_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [$clog2(NUM_CH)-1:0] winner_o,
  output logic                      valid_o
);

  localparam int CH_W = $clog2(NUM_CH);

  int idx;

  // Scan from the farthest offset back to the pointer so the nearest
  // eligible channel is the last one written and therefore wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_CH;
      if (eligible_i[idx[CH_W-1:0]]) begin
        winner_o = idx[CH_W-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdw_tx_arbiter.sv
// rtl/pdw_tx_arbiter.sv - shares one snapshot serializer between NUM_CH FIR channels
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   enable_i     gates new launches; an in-flight frame always completes
//   ch_mask_i    per-channel eligibility mask
//   req_i        per-channel level request (snapshot held in ss_buff_i)
//   ss_buff_i    channel c buffer at [c*SS_BUFF_SZ +: SS_BUFF_SZ]
//   grant_o      one-hot single-cycle grant to the winning channel
//   tx_idle_i    serializer idle
//   tx_start_o   single-cycle serializer launch
//   tx_buff_o    latched winner buffer, stable until the next launch
//   tx_ch_o      channel of the current/last frame
//   busy_o       high whenever the FSM is not in IDLE
//   err_o        sticky accept-timeout flag, cleared by err_clr_i (set wins)
module pdw_tx_arbiter
  import pdw_tx_arbiter_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SS_BUFF_SZ     = SS_BUFF_SZ_DEF,
  parameter int GAP_CYCLES     = 8,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic [NUM_CH-1:0]            ch_mask_i,
  input  logic [NUM_CH-1:0]            req_i,
  input  logic [NUM_CH*SS_BUFF_SZ-1:0] ss_buff_i,
  output logic [NUM_CH-1:0]            grant_o,
  input  logic                         tx_idle_i,
  output logic                         tx_start_o,
  output logic [SS_BUFF_SZ-1:0]        tx_buff_o,
  output logic [$clog2(NUM_CH)-1:0]    tx_ch_o,
  output logic                         busy_o,
  output logic                         err_o,
  input  logic                         err_clr_i
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TO_W  = cnt_width(ACCEPT_TIMEOUT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  pdw_state_e         state_q;
  logic [CH_W-1:0]    ptr_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  logic [NUM_CH-1:0]     eligible;
  logic [CH_W-1:0]       win_idx;
  logic                  win_valid;
  logic [SS_BUFF_SZ-1:0] win_buff;
  logic [NUM_CH-1:0]     grant_d;
  logic [CH_W-1:0]       ptr_d;

  assign eligible = req_i & ch_mask_i;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (win_idx),
    .valid_o    (win_valid)
  );

  always_comb begin
    win_buff = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_idx == CH_W'(c)) begin
        win_buff = ss_buff_i[c*SS_BUFF_SZ +: SS_BUFF_SZ];
      end
    end
  end

  always_comb begin
    grant_d          = '0;
    grant_d[win_idx] = 1'b1;
    ptr_d            = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      grant_o    <= '0;
      tx_start_o <= 1'b0;
      tx_buff_o  <= '0;
      tx_ch_o    <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      grant_o    <= '0;
      tx_start_o <= 1'b0;
      // Clear first so a timeout set later in this block takes priority.
      if (err_clr_i) begin
        err_o <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (enable_i && tx_idle_i && win_valid) begin
            tx_buff_o  <= win_buff;
            tx_ch_o    <= win_idx;
            grant_o    <= grant_d;
            tx_start_o <= 1'b1;
            ptr_q      <= ptr_d;
            to_cnt_q   <= '0;
            busy_o     <= 1'b1;
            state_q    <= ST_ACCEPT;
          end
        end

        ST_ACCEPT: begin
          if (!tx_idle_i) begin
            state_q <= ST_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            // Serializer never took the frame; flag it and still honour the gap.
            err_o <= 1'b1;
            if (GAP_CYCLES == 0) begin
              busy_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= ST_GAP;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        ST_DONE: begin
          if (tx_idle_i) begin
            if (GAP_CYCLES == 0) begin
              busy_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          // GAP lasts exactly GAP_CYCLES clocks: loaded value down to 1.
          if (gap_cnt_q <= GAP_W'(1)) begin
            busy_o  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        default: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdw_tx_arbiter.sv
// tb/tb_pdw_tx_arbiter.sv - directed self-checking bench for pdw_tx_arbiter
module tb_pdw_tx_arbiter;

  localparam int NCH  = 4;
  localparam int SZ   = 192;
  localparam int BUSY = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              enable;
  logic              err_clr;
  logic [NCH-1:0]    mask;
  logic [NCH-1:0]    req;
  logic [NCH*SZ-1:0] ss_buff;
  logic              hang;

  logic           idle8, start8, busy8, err8;
  logic [NCH-1:0] grant8;
  logic [SZ-1:0]  buff8;
  logic [1:0]     ch8;

  logic           idle0, start0, busy0, err0;
  logic [NCH-1:0] grant0;
  logic [SZ-1:0]  buff0;
  logic [1:0]     ch0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int prev8  = 0, last8 = 0, prev0 = 0, last0 = 0;
  int bcnt8  = 0, bcnt0 = 0;

  pdw_tx_arbiter #(.NUM_CH(NCH), .SS_BUFF_SZ(SZ), .GAP_CYCLES(8), .ACCEPT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .ch_mask_i(mask), .req_i(req),
    .ss_buff_i(ss_buff), .grant_o(grant8), .tx_idle_i(idle8), .tx_start_o(start8),
    .tx_buff_o(buff8), .tx_ch_o(ch8), .busy_o(busy8), .err_o(err8), .err_clr_i(err_clr)
  );

  pdw_tx_arbiter #(.NUM_CH(NCH), .SS_BUFF_SZ(SZ), .GAP_CYCLES(0), .ACCEPT_TIMEOUT(15)) dut_g0 (
    .clk(clk), .rst(rst), .enable_i(enable), .ch_mask_i(mask), .req_i(req),
    .ss_buff_i(ss_buff), .grant_o(grant0), .tx_idle_i(idle0), .tx_start_o(start0),
    .tx_buff_o(buff0), .tx_ch_o(ch0), .busy_o(busy0), .err_o(err0), .err_clr_i(err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      idle8 <= 1'b1; bcnt8 <= 0;
    end else if (start8 && !hang) begin
      idle8 <= 1'b0; bcnt8 <= 1;
    end else if (bcnt8 != 0) begin
      if (bcnt8 == BUSY - 1) begin idle8 <= 1'b1; bcnt8 <= 0; end
      else bcnt8 <= bcnt8 + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      idle0 <= 1'b1; bcnt0 <= 0;
    end else if (start0 && !hang) begin
      idle0 <= 1'b0; bcnt0 <= 1;
    end else if (bcnt0 != 0) begin
      if (bcnt0 == BUSY - 1) begin idle0 <= 1'b1; bcnt0 <= 0; end
      else bcnt0 <= bcnt0 + 1;
    end
  end

  always @(negedge clk) begin
    if (start8) begin prev8 = last8; last8 = cyc; end
    if (start0) begin prev0 = last0; last0 = cyc; end
  end

  task automatic chk(input string tag, input logic [SZ-1:0] obs, input logic [SZ-1:0] exp);
    total++;
    if (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [SZ-1:0] exp_buf(input int c);
    return ss_buff[c*SZ +: SZ];
  endfunction

  task automatic wait_grant(input string tag, output logic [NCH-1:0] g);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1);
      if (grant8 != '0) found = 1'b1;
    end
    g = grant8;
    chk({tag, "_seen"}, SZ'(found), SZ'(1));
  endtask

  task automatic wait_idle(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1);
      if (!busy8) found = 1'b1;
    end
    chk({tag, "_idle"}, SZ'(found), SZ'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] g;
    logic [NCH-1:0] seen;

    enable  = 1'b1;
    err_clr = 1'b0;
    mask    = 4'b1111;
    req     = 4'b0000;
    hang    = 1'b0;
    for (int w = 0; w < NCH * SZ / 32; w++) ss_buff[w*32 +: 32] = $urandom();

    step(2);
    chk("rst_grant", SZ'(grant8), SZ'(0));
    chk("rst_start", SZ'(start8), SZ'(0));
    chk("rst_busy",  SZ'(busy8),  SZ'(0));
    chk("rst_err",   SZ'(err8),   SZ'(0));
    chk("rst_ch",    SZ'(ch8),    SZ'(0));
    chk("rst_buff",  buff8,       SZ'(0));
    rst = 1'b0;
    step(1);

    req = 4'b0010;
    step(1);
    chk("t1_grant", SZ'(grant8), SZ'(4'b0010));
    chk("t1_start", SZ'(start8), SZ'(1));
    chk("t1_ch",    SZ'(ch8),    SZ'(1));
    chk("t1_buff",  buff8,       exp_buf(1));
    chk("t1_busy",  SZ'(busy8),  SZ'(1));
    req = 4'b0000;
    step(1);
    chk("t1_grant_pulse", SZ'(grant8), SZ'(0));
    chk("t1_start_pulse", SZ'(start8), SZ'(0));
    wait_idle("t1");
    chk("t1_buff_hold", buff8, exp_buf(1));

    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant("t2_rr", g);
      chk("t2_rr_order", SZ'(g), SZ'(4'b0001 << i));
      req = req & ~g;
    end
    req = 4'b1001;
    wait_grant("t2_a", g);
    chk("t2_a_order", SZ'(g), SZ'(4'b0001));
    req = req & ~g;
    wait_grant("t2_b", g);
    chk("t2_b_order", SZ'(g), SZ'(4'b1000));
    chk("t2_b_ch",    SZ'(ch8), SZ'(3));
    req = 4'b1001;
    wait_grant("t2_wrap", g);
    chk("t2_wrap_order", SZ'(g), SZ'(4'b0001));
    req = 4'b0000;
    wait_idle("t2");

    do_reset();
    req = 4'b0001;
    step(450);
    chk("t3_spacing_gap8", SZ'(last8 - prev8), SZ'(1 + BUSY + 8 + 1));
    chk("t3_spacing_gap0", SZ'(last0 - prev0), SZ'(1 + BUSY + 0 + 1));
    req = 4'b0000;
    wait_idle("t3");

    do_reset();
    hang = 1'b1;
    req  = 4'b0100;
    wait_grant("t4_a", g);
    chk("t4_a_grant", SZ'(g), SZ'(4'b0100));
    req = 4'b0000;
    step(14);
    chk("t4_err_before", SZ'(err8), SZ'(0));
    step(1);
    chk("t4_err_at15",   SZ'(err8),  SZ'(1));
    chk("t4_busy_gap",   SZ'(busy8), SZ'(1));
    step(7);
    chk("t4_busy_gapend", SZ'(busy8), SZ'(1));
    step(1);
    chk("t4_idle_after_gap", SZ'(busy8), SZ'(0));
    chk("t4_err_sticky",     SZ'(err8),  SZ'(1));
    err_clr = 1'b1;
    step(1);
    chk("t4_err_clr", SZ'(err8), SZ'(0));
    err_clr = 1'b0;
    req = 4'b0100;
    wait_grant("t4_b", g);
    req = 4'b0000;
    step(14);
    err_clr = 1'b1;
    step(1);
    chk("t4_set_wins", SZ'(err8), SZ'(1));
    step(1);
    chk("t4_clr_after", SZ'(err8), SZ'(0));
    err_clr = 1'b0;
    hang    = 1'b0;
    wait_idle("t4");

    do_reset();
    mask = 4'b1101;
    req  = 4'b0010;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      seen = seen | grant8;
    end
    chk("t5_masked_grant", SZ'(seen),  SZ'(0));
    chk("t5_masked_busy",  SZ'(busy8), SZ'(0));
    mask = 4'b1111;
    step(1);
    chk("t5_unmask_grant", SZ'(grant8), SZ'(4'b0010));
    step(4);
    enable = 1'b0;
    wait_idle("t5_frame_done");
    seen = '0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      seen = seen | {3'b000, start8};
    end
    chk("t5_disabled_start", SZ'(seen), SZ'(0));
    enable = 1'b1;
    step(1);
    chk("t5_reenable_start", SZ'(start8), SZ'(1));
    req = 4'b0000;
    wait_idle("t5");

    do_reset();
    req = 4'b0100;
    step(1);
    chk("t6_grant", SZ'(grant8), SZ'(4'b0100));
    req = 4'b0000;
    step(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy",  SZ'(busy8),  SZ'(0));
    chk("t6_rst_grant", SZ'(grant8), SZ'(0));
    chk("t6_rst_start", SZ'(start8), SZ'(0));
    chk("t6_rst_ch",    SZ'(ch8),    SZ'(0));
    chk("t6_rst_buff",  buff8,       SZ'(0));
    req = 4'b1100;
    step(2);
    rst = 1'b0;
    step(1);
    chk("t6_post_grant", SZ'(grant8), SZ'(4'b0100));
    chk("t6_post_buff",  buff8,       exp_buf(2));
    req = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
